tick_divider_bank: RTL and testbench

//  Parametrised bank of NUM_CH independent clock-enable dividers off the PLL output clock.

---
 rtl/tick_divider_bank_pkg.sv | 11 +
 rtl/tick_divider_bank_if.sv | 23 ++
 rtl/tick_divider_bank_ch.sv | 48 ++++
 rtl/tick_divider_bank.sv | 94 +++++++++
 tb/tb_tick_divider_bank.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tick_divider_bank_pkg.sv
// Shared types and defaults for the tick divider bank.
package tick_div_pkg;
  localparam int NUM_CH_DEF = 4;
  localparam int DEFAULT_PERIOD = 16000000;
  localparam int CH_IDX_W = $clog2(NUM_CH_DEF) + 1;

  typedef enum logic {
    IDLE,
    PEND
  } state_e;
endpackage

// File: rtl/tick_divider_bank_if.sv
// Period-update request channel for the tick divider bank.
interface tick_divider_bank_if
  import tick_div_pkg::*;
#(
  parameter int CH_W  = CH_IDX_W,
  parameter int CNT_W = 24
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [CNT_W-1:0] cfg_period;
  logic             cfg_err;

  modport master (
    output cfg_valid, cfg_ch, cfg_period,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_period,
    output cfg_ready, cfg_err
  );
endinterface

// File: rtl/tick_divider_bank_ch.sv
// One divider channel: prescaler, period register and event counter.
module tick_div_ch #(
  parameter int          CNT_W          = 24,
  parameter int          OUT_W          = 8,
  parameter int unsigned DEFAULT_PERIOD = 16000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             tick,
  output logic             wrap_next,
  output logic [OUT_W-1:0] count
);
  logic [CNT_W-1:0] presc;
  logic [CNT_W-1:0] period;

  assign wrap_next = en && (presc == period);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc  <= '0;
      period <= CNT_W'(DEFAULT_PERIOD);
      tick   <= 1'b0;
      count  <= '0;
    end else begin
      if (!en) begin
        presc <= '0;
        tick  <= 1'b0;
      end else if (wrap_next) begin
        presc <= '0;
        tick  <= 1'b1;
      end else begin
        presc <= presc + 1'b1;
        tick  <= 1'b0;
      end
      // clear wins over the increment
      if (clr)
        count <= '0;
      else if (wrap_next)
        count <= count + 1'b1;
      if (load)
        period <= load_val;
    end
  end
endmodule

// File: rtl/tick_divider_bank.sv
// Bank of clock-enable dividers with glitch-free period reprogramming.
module tick_divider_bank #(
  parameter int          NUM_CH         = 4,
  parameter int          CNT_W          = 24,
  parameter int          OUT_W          = 8,
  parameter int unsigned DEFAULT_PERIOD = tick_div_pkg::DEFAULT_PERIOD
) (
  input  logic                    hwclk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic [NUM_CH-1:0]       cnt_clr,
  tick_divider_bank_if.slave      cfg,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH*OUT_W-1:0] count_out,
  output logic [NUM_CH-1:0]       led
);
  import tick_div_pkg::*;

  localparam int CH_W = $clog2(NUM_CH) + 1;

  state_e           state;
  state_e           state_nxt;
  logic [CH_W-1:0]  stage_ch;
  logic [CNT_W-1:0] stage_period;
  logic [NUM_CH-1:0] wrap_next;
  logic [NUM_CH-1:0] load;
  logic             accept;
  logic             bad_ch;

  assign accept        = cfg.cfg_valid && (state == IDLE);
  assign bad_ch        = cfg.cfg_ch >= CH_W'(NUM_CH);
  assign cfg.cfg_ready = (state == IDLE);

  always_ff @(posedge hwclk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // a disabled channel has no wrap to wait for, so load at once
  always_comb begin
    state_nxt = state;
    load      = '0;
    unique case (state)
      IDLE: begin
        if (accept && !bad_ch)
          state_nxt = PEND;
      end
      PEND: begin
        for (int i = 0; i < NUM_CH; i++)
          if (stage_ch == CH_W'(i) &&
              (wrap_next[i] || !ch_en[i]))
            load[i] = 1'b1;
        if (|load)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge hwclk or negedge rst_n) begin
    if (!rst_n) begin
      stage_ch     <= '0;
      stage_period <= '0;
      cfg.cfg_err  <= 1'b0;
    end else begin
      cfg.cfg_err <= accept && bad_ch;
      if (accept && !bad_ch) begin
        stage_ch     <= cfg.cfg_ch;
        stage_period <= cfg.cfg_period;
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    tick_div_ch #(
      .CNT_W          (CNT_W),
      .OUT_W          (OUT_W),
      .DEFAULT_PERIOD (DEFAULT_PERIOD)
    ) u_ch (
      .clk       (hwclk),
      .rst_n     (rst_n),
      .en        (ch_en[g]),
      .clr       (cnt_clr[g]),
      .load      (load[g]),
      .load_val  (stage_period),
      .tick      (tick[g]),
      .wrap_next (wrap_next[g]),
      .count     (count_out[g*OUT_W +: OUT_W])
    );
    assign led[g] = count_out[g*OUT_W];
  end
endmodule

// File: tb/tb_tick_divider_bank.sv
// Directed bench for tick_divider_bank (4 ch, period 9, 4-bit counters).
module tb_tick_divider_bank;
  localparam int NUM_CH = 4;
  localparam int CNT_W  = 8;
  localparam int OUT_W  = 4;
  localparam int CH_W   = 3;

  logic        hwclk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  ch_en = '0;
  logic [3:0]  cnt_clr = '0;
  logic [3:0]  tick;
  logic [3:0]  led;
  logic [15:0] count_out;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 hwclk = ~hwclk;

  tick_divider_bank_if #(.CH_W(CH_W), .CNT_W(CNT_W)) cfg_if ();

  tick_divider_bank #(
    .NUM_CH         (NUM_CH),
    .CNT_W          (CNT_W),
    .OUT_W          (OUT_W),
    .DEFAULT_PERIOD (9)
  ) dut (
    .hwclk     (hwclk),
    .rst_n     (rst_n),
    .ch_en     (ch_en),
    .cnt_clr   (cnt_clr),
    .cfg       (cfg_if),
    .tick      (tick),
    .count_out (count_out),
    .led       (led)
  );

  function automatic logic [3:0] cnt(int ch);
    return count_out[ch*4 +: 4];
  endfunction

  task automatic step();
    @(negedge hwclk);
    cyc++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ch_en = '0;
    cnt_clr = '0;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_ch = '0;
    cfg_if.cfg_period = '0;
    repeat (3) @(negedge hwclk);
    checks++;
    if (tick !== 4'h0) begin
      errors++; $display("FAIL rst_tick got %h want 0", tick);
    end
    checks++;
    if (count_out !== 16'h0) begin
      errors++; $display("FAIL rst_count got %h want 0", count_out);
    end
    checks++;
    if (led !== 4'h0) begin
      errors++; $display("FAIL rst_led got %h want 0", led);
    end
    checks++;
    if (cfg_if.cfg_ready !== 1'b1) begin
      errors++; $display("FAIL rst_ready got %b want 1", cfg_if.cfg_ready);
    end
    checks++;
    if (cfg_if.cfg_err !== 1'b0) begin
      errors++; $display("FAIL rst_err got %b want 0", cfg_if.cfg_err);
    end
  endtask

  task automatic test_startup();
    logic [3:0] exp;
    rst_n = 1'b1;
    ch_en = 4'hF;
    cyc = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      exp = (k == 10 || k == 20) ? 4'hF : 4'h0;
      checks++;
      if (tick !== exp) begin
        errors++;
        $display("FAIL start_tick c%0d got %h want %h", k, tick, exp);
      end
      if (k == 10) begin
        checks++;
        if (led !== 4'hF) begin
          errors++; $display("FAIL start_led got %h want F", led);
        end
      end
    end
    checks++;
    if (count_out !== 16'h2222) begin
      errors++; $display("FAIL start_cnt got %h want 2222", count_out);
    end
    checks++;
    if (led !== 4'h0) begin
      errors++; $display("FAIL start_led2 got %h want 0", led);
    end
  endtask

  task automatic test_wrap();
    while (cyc < 150) step();
    checks++;
    if (cnt(0) !== 4'hF || led[0] !== 1'b1) begin
      errors++;
      $display("FAIL wrap_pre got %h/%b want F/1", cnt(0), led[0]);
    end
    while (cyc < 160) step();
    checks++;
    if (cnt(0) !== 4'h0 || led[0] !== 1'b0 || tick[0] !== 1'b1) begin
      errors++;
      $display("FAIL wrap got %h/%b/%b want 0/0/1", cnt(0), led[0], tick[0]);
    end
  endtask

  task automatic test_cfg();
    logic exp;
    while (cyc < 163) step();
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_ch = 3'd2;
    cfg_if.cfg_period = 8'd3;
    checks++;
    if (cfg_if.cfg_ready !== 1'b1) begin
      errors++; $display("FAIL cfg_rdy0 got %b want 1", cfg_if.cfg_ready);
    end
    step();
    cfg_if.cfg_valid = 1'b0;
    checks++;
    if (cfg_if.cfg_ready !== 1'b0) begin
      errors++; $display("FAIL cfg_rdy_pend got %b want 0", cfg_if.cfg_ready);
    end
    while (cyc < 169) begin
      step();
      checks++;
      if (cfg_if.cfg_ready !== 1'b0 || tick[2] !== 1'b0) begin
        errors++;
        $display("FAIL cfg_hold c%0d got %b/%b want 0/0",
                 cyc, cfg_if.cfg_ready, tick[2]);
      end
    end
    step();
    checks++;
    if (tick[2] !== 1'b1 || cfg_if.cfg_ready !== 1'b1 || cnt(2) !== 4'h1) begin
      errors++;
      $display("FAIL cfg_load got %b/%b/%h want 1/1/1",
               tick[2], cfg_if.cfg_ready, cnt(2));
    end
    while (cyc < 178) begin
      step();
      exp = (cyc == 174 || cyc == 178);
      checks++;
      if (tick[2] !== exp) begin
        errors++;
        $display("FAIL cfg_new c%0d got %b want %b", cyc, tick[2], exp);
      end
    end
    while (cyc < 180) step();
    checks++;
    if (tick[0] !== 1'b1 || tick[2] !== 1'b0) begin
      errors++;
      $display("FAIL cfg_other got %b/%b want 1/0", tick[0], tick[2]);
    end
  endtask

  task automatic test_err();
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_ch = 3'd5;
    cfg_if.cfg_period = 8'd1;
    step();
    cfg_if.cfg_valid = 1'b0;
    checks++;
    if (cfg_if.cfg_err !== 1'b1 || cfg_if.cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL err_pulse got %b/%b want 1/1",
               cfg_if.cfg_err, cfg_if.cfg_ready);
    end
    step();
    checks++;
    if (cfg_if.cfg_err !== 1'b0 || cfg_if.cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL err_end got %b/%b want 0/1",
               cfg_if.cfg_err, cfg_if.cfg_ready);
    end
    while (cyc < 189) step();
    checks++;
    if (tick !== 4'h0) begin
      errors++; $display("FAIL err_t189 got %h want 0", tick);
    end
    step();
    checks++;
    if (tick !== 4'hF) begin
      errors++; $display("FAIL err_t190 got %h want F", tick);
    end
    while (cyc < 200) step();
    checks++;
    if (tick !== 4'b1011) begin
      errors++; $display("FAIL err_t200 got %h want B", tick);
    end
  endtask

  task automatic test_clr_en();
    ch_en = 4'b0111;
    while (cyc < 209) begin
      step();
      checks++;
      if (tick[3] !== 1'b0) begin
        errors++; $display("FAIL dis_tick c%0d got 1 want 0", cyc);
      end
    end
    cnt_clr = 4'b0010;
    step();
    cnt_clr = 4'b0000;
    checks++;
    if (tick[1] !== 1'b1 || cnt(1) !== 4'h0 || led[1] !== 1'b0) begin
      errors++;
      $display("FAIL clr got %b/%h/%b want 1/0/0", tick[1], cnt(1), led[1]);
    end
    checks++;
    if (cnt(0) !== 4'h5) begin
      errors++; $display("FAIL clr_ch0 got %h want 5", cnt(0));
    end
    while (cyc < 225) begin
      step();
      checks++;
      if (tick[3] !== 1'b0 || cnt(3) !== 4'h4) begin
        errors++;
        $display("FAIL dis c%0d got %b/%h want 0/4", cyc, tick[3], cnt(3));
      end
      if (cyc == 220) begin
        checks++;
        if (cnt(1) !== 4'h1) begin
          errors++; $display("FAIL clr_after got %h want 1", cnt(1));
        end
      end
    end
    ch_en = 4'hF;
    while (cyc < 235) step();
    checks++;
    if (tick[3] !== 1'b1 || cnt(3) !== 4'h5) begin
      errors++;
      $display("FAIL reen got %b/%h want 1/5", tick[3], cnt(3));
    end
  endtask

  task automatic test_reset_pend();
    logic exp;
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_ch = 3'd2;
    cfg_if.cfg_period = 8'd5;
    step();
    cfg_if.cfg_valid = 1'b0;
    checks++;
    if (cfg_if.cfg_ready !== 1'b0) begin
      errors++; $display("FAIL rp_pend got %b want 0", cfg_if.cfg_ready);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (cfg_if.cfg_ready !== 1'b1 || count_out !== 16'h0 || tick !== 4'h0) begin
      errors++;
      $display("FAIL rp_async got %b/%h/%h want 1/0/0",
               cfg_if.cfg_ready, count_out, tick);
    end
    repeat (2) @(negedge hwclk);
    rst_n = 1'b1;
    cyc = 0;
    while (cyc < 20) begin
      step();
      exp = (cyc == 10 || cyc == 20);
      checks++;
      if (tick[2] !== exp) begin
        errors++;
        $display("FAIL rp_tick c%0d got %b want %b", cyc, tick[2], exp);
      end
    end
    checks++;
    if (cfg_if.cfg_ready !== 1'b1 || count_out !== 16'h2222) begin
      errors++;
      $display("FAIL rp_end got %b/%h want 1/2222",
               cfg_if.cfg_ready, count_out);
    end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_wrap();
    test_cfg();
    test_err();
    test_clr_en();
    test_reset_pend();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
